led_decoder_seq: RTL and testbench



---
 rtl/led_decoder_pkg.sv | 19 +
 rtl/onehot_decoder.sv | 13 +
 rtl/led_decoder_seq.sv | 68 ++++++
 tb/tb_led_decoder_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_decoder_pkg.sv
// led_decoder_pkg: mode/state encodings shared by the led decoder block
package led_decoder_pkg;
  localparam logic [1:0] MODE_DECODE    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_PINGPONG  = 2'b11;
  typedef enum logic [1:0] {
    M_DECODE    = MODE_DECODE,
    M_SCAN_UP   = MODE_SCAN_UP,
    M_SCAN_DOWN = MODE_SCAN_DOWN,
    M_PINGPONG  = MODE_PINGPONG
  } mode_t;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_UP   = 2'd2,
    S_DOWN = 2'd3
  } state_t;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: combinational one-hot decode with enable and output polarity
module onehot_decoder #(
  parameter int SEL_W      = 3,
  parameter int OUTS       = 2**SEL_W,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUTS-1:0]  led
);
  localparam logic POL = ACTIVE_LOW != 0;
  assign led = {OUTS{POL}} ^ ({{(OUTS-1){1'b0}}, en} << sel);
endmodule

// File: rtl/led_decoder_seq.sv
// led_decoder_seq: prescaled index sequencer (hold/scan/pingpong) driving a one-hot led bank
module led_decoder_seq
  import led_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int OUTS       = 2**SEL_W,
  parameter int DIV_W      = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic [OUTS-1:0]  led,
  output logic [SEL_W-1:0] index,
  output logic             wrap
);
  state_t           state, state_d;
  mode_t            m;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] idx_d;
  logic             dir, dir_d, dir_eff, chg, enter, step, top, bot, bounce, inc, dec, wrap_d, pp;
  assign m = mode_t'(mode);
  always_comb begin
    pp      = m == M_PINGPONG;
    chg     = en && mode != mode_q;
    enter   = en && pp && (chg || state == S_IDLE);
    dir_eff = enter || dir;
    step    = en && !load && !chg && cnt == div;
    top     = index == SEL_W'(OUTS-1);
    bot     = index == '0;
    bounce  = pp && (dir_eff ? top : bot);
    inc     = m == M_SCAN_UP || (pp && (dir_eff ? !top : bot));
    dec     = m == M_SCAN_DOWN || (pp && (dir_eff ? top : !bot));
    idx_d   = load ? sel : !step ? index : inc ? index + SEL_W'(1) : dec ? index - SEL_W'(1) : index;
    wrap_d  = step && ((m == M_SCAN_UP && top) || (m == M_SCAN_DOWN && bot) || bounce);
    dir_d   = (step && bounce) ? !dir_eff : dir_eff;
    cnt_d   = (!en || load || chg || step) ? '0 : cnt + DIV_W'(1);
    state_d = !en ? S_IDLE : m == M_DECODE ? S_HOLD : m == M_SCAN_UP ? S_UP :
              m == M_SCAN_DOWN ? S_DOWN : dir_d ? S_UP : S_DOWN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      index  <= '0;
      cnt    <= '0;
      dir    <= 1'b1;
      wrap   <= 1'b0;
      mode_q <= mode;
    end else begin
      state  <= state_d;
      index  <= idx_d;
      cnt    <= cnt_d;
      dir    <= dir_d;
      wrap   <= wrap_d;
      mode_q <= mode;
    end
  end
  onehot_decoder #(.SEL_W(SEL_W), .OUTS(OUTS), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (
    .sel(index),
    .en (state != S_IDLE),
    .led(led)
  );
endmodule

// File: tb/tb_led_decoder_seq.sv
// tb_led_decoder_seq: directed and random checks of led_decoder_seq against a behavioural model
module tb_led_decoder_seq;
  localparam int N = 8;
  logic       clk = 0, rst_n = 0, en = 0, load = 0;
  logic [1:0] mode = 0;
  logic [2:0] sel = 0;
  logic [7:0] div = 0;
  logic [7:0] led, led_n;
  logic [2:0] index, index_n;
  logic       wrap, wrap_n;
  int  n_checks = 0, n_pass = 0;
  int  m_idx = 0, m_cnt = 0, m_mprev = 0;
  bit  m_dir = 1, m_wrap = 0, m_act = 0;

  led_decoder_seq #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load), .div(div),
    .led(led), .index(index), .wrap(wrap));
  led_decoder_seq #(.SEL_W(3), .DIV_W(8), .ACTIVE_LOW(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load), .div(div),
    .led(led_n), .index(index_n), .wrap(wrap_n));

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_led();
    return m_act ? 8'(1 << m_idx) : 8'h00;
  endfunction

  // Advance one clock and update the model from the inputs sampled at that edge.
  task automatic tick();
    bit chg, stp;
    @(posedge clk);
    if (!rst_n) begin
      m_idx = 0; m_cnt = 0; m_dir = 1; m_wrap = 0; m_act = 0; m_mprev = int'(mode);
    end else begin
      chg = en && int'(mode) != m_mprev;
      if (en && mode == 3 && (chg || !m_act)) m_dir = 1;
      stp = en && !load && !chg && m_cnt == int'(div);
      m_wrap = 0;
      if (load) m_idx = int'(sel);
      else if (stp) begin
        if (mode == 1) begin m_wrap = m_idx == N-1; m_idx = (m_idx + 1) % N; end
        else if (mode == 2) begin m_wrap = m_idx == 0; m_idx = (m_idx + N - 1) % N; end
        else if (mode == 3) begin
          if (m_dir && m_idx == N-1) begin m_dir = 0; m_idx = N-2; m_wrap = 1; end
          else if (!m_dir && m_idx == 0) begin m_dir = 1; m_idx = 1; m_wrap = 1; end
          else m_idx = m_dir ? m_idx + 1 : m_idx - 1;
        end
      end
      m_cnt = (!en || load || chg || stp) ? 0 : (m_cnt + 1) % 256;
      m_act = en;
      m_mprev = int'(mode);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; load = 1; sel = 5; mode = 1;
    tick(); tick();
    n_checks++;
    if ({led, led_n, index, wrap} !== {8'h00, 8'hFF, 3'd0, 1'b0})
      $display("FAIL reset: got led=%h led_n=%h idx=%0d wrap=%b want 00 FF 0 0", led, led_n, index, wrap);
    else n_pass++;
    rst_n = 1; load = 0; en = 0;
    tick();
  endtask

  task automatic test_decode();
    en = 1; mode = 0; sel = 5; load = 1;
    tick();
    load = 0; sel = 2;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({led, led_n, index, wrap} !== {8'h20, 8'hDF, 3'd5, 1'b0})
        $display("FAIL decode c%0d: got led=%h led_n=%h idx=%0d wrap=%b want 20 DF 5 0", i, led, led_n, index, wrap);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_scan_up();
    logic [2:0] exp_i;
    int wraps = 0;
    en = 0; tick();
    en = 1; mode = 1; div = 2; sel = 6; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 9; i++) begin
      exp_i = 3'(6 + i / 3);
      n_checks++;
      if ({led, led_n, index, wrap} !== {8'(1 << exp_i), ~8'(1 << exp_i), exp_i, 1'(i == 6)})
        $display("FAIL scan_up c%0d: got led=%h idx=%0d wrap=%b want led=%h idx=%0d wrap=%b",
                 i, led, index, wrap, 8'(1 << exp_i), exp_i, i == 6);
      else n_pass++;
      wraps += int'(wrap);
      tick();
    end
    n_checks++;
    if (wraps !== 1) $display("FAIL scan_up_wraps: got %0d want 1", wraps);
    else n_pass++;
  endtask

  task automatic test_pingpong();
    int seq [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int wraps = 0;
    en = 0; tick();
    en = 1; mode = 3; div = 0; sel = 0; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({led, index, wrap} !== {8'(1 << seq[i]), 3'(seq[i]), 1'(i == 8 || i == 15)})
        $display("FAIL pingpong c%0d: got led=%h idx=%0d wrap=%b want idx=%0d wrap=%b",
                 i, led, index, wrap, seq[i], i == 8 || i == 15);
      else n_pass++;
      wraps += int'(wrap);
      if (i < 15) tick();
    end
    n_checks++;
    if (wraps !== 2) $display("FAIL pingpong_wraps: got %0d want 2", wraps);
    else n_pass++;
  endtask

  task automatic test_load_on_step();
    en = 1; mode = 1; div = 0; sel = 7; load = 1;
    tick();
    sel = 2;
    tick();
    load = 0;
    n_checks++;
    if ({led, index, wrap} !== {8'h04, 3'd2, 1'b0})
      $display("FAIL load_on_step: got led=%h idx=%0d wrap=%b want 04 2 0", led, index, wrap);
    else n_pass++;
  endtask

  task automatic test_active_low();
    en = 1; mode = 0; sel = 0; load = 1;
    tick();
    load = 0;
    n_checks++;
    if ({led_n, index_n} !== {8'hFE, 3'd0})
      $display("FAIL active_low_on: got led=%h idx=%0d want FE 0", led_n, index_n);
    else n_pass++;
    en = 0;
    tick();
    n_checks++;
    if ({led_n, index_n, led} !== {8'hFF, 3'd0, 8'h00})
      $display("FAIL active_low_off: got led_n=%h idx=%0d led=%h want FF 0 00", led_n, index_n, led);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      en    = $urandom_range(0, 9) != 0;
      load  = $urandom_range(0, 9) == 0;
      sel   = 3'($urandom);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 29) == 0) div = 8'($urandom_range(0, 3));
      tick();
      n_checks++;
      if ({led, led_n, index, wrap} !== {exp_led(), ~exp_led(), 3'(m_idx), m_wrap})
        $display("FAIL random c%0d: got led=%h led_n=%h idx=%0d wrap=%b want led=%h idx=%0d wrap=%b",
                 i, led, led_n, index, wrap, exp_led(), m_idx, m_wrap);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_scan_up();
    test_pingpong();
    test_load_on_step();
    test_active_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
